// File: rtl/mem_access_ctrl.sv
// LC3 memory-block sequencer: serialises fetch (port 0) and data (port 1) single-word
// requests onto MAR/MDR/memory strobes. Define MEM_ACCESS_CTRL_RR_EN for round-robin arbitration.
module mem_access_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [DATA_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [DATA_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] mdr_out,
  output logic [DATA_W-1:0] mem_bus,
  output logic              bus_en,
  output logic              ld_mar,
  output logic              ld_mdr,
  output logic              sel_mdr,
  output logic              mem_we,
  output logic              busy,
  output logic              grant_id
);
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_LD_MAR, S_WAIT, S_LD_MDR, S_WRITE, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] mem_bus;
    logic              bus_en;
    logic              ld_mar;
    logic              ld_mdr;
    logic              sel_mdr;
    logic              mem_we;
    logic              p0_ack;
    logic              p1_ack;
    logic              busy;
    logic              grant_id;
  } ctrl_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic              we_q, we_d, id_q, id_d;
  logic              win_id;
  ctrl_t             ctrl_q, ctrl_d;

`ifdef MEM_ACCESS_CTRL_RR_EN
  // Contested requests go to the port that was not served last.
  logic last_grant_q;

  always_comb begin
    if (p0_req && p1_req) win_id = ~last_grant_q;
    else                  win_id = p1_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       last_grant_q <= 1'b1;
    else if (state_q == S_IDLE && (p0_req || p1_req)) last_grant_q <= win_id;
  end
`else
  assign win_id = p1_req;
`endif

  // Next state plus the strobe pattern of the state being entered, so strobes are registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    id_d    = id_q;
    ctrl_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          id_d    = win_id;
          addr_d  = win_id ? p1_addr  : p0_addr;
          wdata_d = win_id ? p1_wdata : p0_wdata;
          we_d    = win_id ? p1_we    : p0_we;
          state_d = S_LD_MAR;
        end
      end
      S_LD_MAR: begin
        cnt_d   = '0;
        state_d = (MEM_WAIT > 0) ? S_WAIT : S_LD_MDR;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == WAIT_LAST) state_d = S_LD_MDR;
      end
      S_LD_MDR: state_d = we_q ? S_WRITE : S_DONE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    case (state_d)
      S_LD_MAR: begin
        ctrl_d.mem_bus = addr_d;
        ctrl_d.bus_en  = 1'b1;
        ctrl_d.ld_mar  = 1'b1;
      end
      S_LD_MDR: begin
        ctrl_d.ld_mdr = 1'b1;
        if (we_d) begin
          ctrl_d.mem_bus = wdata_d;
          ctrl_d.bus_en  = 1'b1;
        end else begin
          ctrl_d.sel_mdr = 1'b1;
        end
      end
      S_WRITE: ctrl_d.mem_we = 1'b1;
      S_DONE: begin
        ctrl_d.p0_ack = ~id_d;
        ctrl_d.p1_ack = id_d;
      end
      default: ;
    endcase
    ctrl_d.busy     = (state_d != S_IDLE);
    ctrl_d.grant_id = (state_d != S_IDLE) && id_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      id_q    <= id_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign mem_bus  = ctrl_q.mem_bus;
  assign bus_en   = ctrl_q.bus_en;
  assign ld_mar   = ctrl_q.ld_mar;
  assign ld_mdr   = ctrl_q.ld_mdr;
  assign sel_mdr  = ctrl_q.sel_mdr;
  assign mem_we   = ctrl_q.mem_we;
  assign p0_ack   = ctrl_q.p0_ack;
  assign p1_ack   = ctrl_q.p1_ack;
  assign busy     = ctrl_q.busy;
  assign grant_id = ctrl_q.grant_id;

  // MDR already holds the read word during the ack cycle.
  assign rdata = (ctrl_q.p0_ack || ctrl_q.p1_ack) ? mdr_out : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: MAR/MDR/memory model, strobe-level sequences, a transaction table
// and randomized streams checked against a transaction-level scheduling model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int unsigned DW = 16;
`ifdef MEM_ACCESS_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, preload;
  logic p0_req, p0_we, p1_req, p1_we;
  logic [DW-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic p0_ack, p1_ack, bus_en, ld_mar, ld_mdr, sel_mdr, mem_we, busy, grant_id;
  logic [DW-1:0] rdata, mdr_out, mem_bus;

  logic w_req;
  logic [DW-1:0] w_addr, w_zero;
  logic w_zbit;
  logic w_p0_ack, w_p1_ack, w_bus_en, w_ld_mar, w_ld_mdr, w_sel_mdr, w_mem_we, w_busy, w_grant_id;
  logic [DW-1:0] w_rdata, w_mdr, w_mem_bus, w_mar;

  mem_access_ctrl #(.DATA_W(DW), .MEM_WAIT(0)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
    .rdata(rdata), .mdr_out(mdr_out), .mem_bus(mem_bus), .bus_en(bus_en), .ld_mar(ld_mar),
    .ld_mdr(ld_mdr), .sel_mdr(sel_mdr), .mem_we(mem_we), .busy(busy), .grant_id(grant_id));

  mem_access_ctrl #(.DATA_W(DW), .MEM_WAIT(3)) dut_w (
    .clk(clk), .reset(reset),
    .p0_req(w_req), .p0_we(w_zbit), .p0_addr(w_addr), .p0_wdata(w_zero), .p0_ack(w_p0_ack),
    .p1_req(w_zbit), .p1_we(w_zbit), .p1_addr(w_zero), .p1_wdata(w_zero), .p1_ack(w_p1_ack),
    .rdata(w_rdata), .mdr_out(w_mdr), .mem_bus(w_mem_bus), .bus_en(w_bus_en), .ld_mar(w_ld_mar),
    .ld_mdr(w_ld_mdr), .sel_mdr(w_sel_mdr), .mem_we(w_mem_we), .busy(w_busy), .grant_id(w_grant_id));

  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'h1234;
    if (a == 8'h30) return 16'h5555;
    return {a, ~a};
  endfunction

  // Memory block model: MAR, MDR and a 256-word array indexed by the low address byte.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] mar, mdr;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else begin
      if (ld_mar) mar <= mem_bus;
      if (ld_mdr) mdr <= sel_mdr ? mem[mar[7:0]] : mem_bus;
      if (mem_we) mem[mar[7:0]] <= mdr;
    end
  end
  assign mdr_out = mdr;

  always @(posedge clk) begin
    if (w_ld_mar) w_mar <= w_mem_bus;
    if (w_ld_mdr) w_mdr <= w_sel_mdr ? init_val(w_mar[7:0]) : w_mem_bus;
  end

  int overlap_cnt = 0, ack_cnt = 0, we_cnt = 0;
  always @(negedge clk) begin
    if (p0_ack && p1_ack) overlap_cnt <= overlap_cnt + 1;
    if (p0_ack || p1_ack) ack_cnt <= ack_cnt + 1;
    if (mem_we)           we_cnt  <= we_cnt + 1;
  end

  int n_checks = 0, n_pass = 0;
  logic [DW-1:0] ref_mem [256];

  typedef struct packed { logic we; logic [DW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  req_t q0[$], q1[$];

  typedef struct packed {
    logic port; logic we; logic [DW-1:0] addr; logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata; logic [3:0] exp_lat;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ctrl"}, 32'({busy, p0_ack, p1_ack, bus_en, ld_mar, ld_mdr, sel_mdr, mem_we, grant_id}), 0);
    check({tag, " bus"}, 32'(mem_bus), 0);
    check({tag, " rdata"}, 32'(rdata), 0);
  endtask

  task automatic do_single(input logic port, input logic we, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, output logic got_port, output int lat,
                           output logic [DW-1:0] got_rd);
    if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    lat = 0;
    while (!(p0_ack || p1_ack) && lat < 20) begin
      tick();
      lat++;
    end
    got_port = p1_ack;
    got_rd   = rdata;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
  endtask

  task automatic present(input int e, input int d);
    p1_req = (q1.size() != 0);
    if (p1_req) {p1_we, p1_addr, p1_wdata} = q1[0];
    p0_req = (e >= d) && (q0.size() != 0);
    if (p0_req) {p0_we, p0_addr, p0_wdata} = q0[0];
  endtask

  // Runs the q0/q1 streams from reset (port 0 joins after d cycles) against a schedule built
  // from the arbitration rule, per-operation latency and one idle cycle between grants.
  task automatic run_stream(input string tag, input int d);
    req_t m0[$], m1[$];
    int ep[$], ee[$];
    logic [16:0] er[$];
    logic [DW-1:0] mm [256];
    int t, lat, e, got;
    logic lg, win;
    req_t r;
    m0 = q0; m1 = q1; mm = ref_mem; t = 1; lg = 1'b1;
    while (m0.size() + m1.size() > 0) begin
      if (m1.size() == 0 && t < d + 1) t = d + 1;
      if (m1.size() != 0 && m0.size() != 0 && t >= d + 1) win = RR ? ~lg : 1'b1;
      else win = (m1.size() != 0);
      lg = win;
      if (win) r = m1.pop_front();
      else     r = m0.pop_front();
      lat = 3 + int'(r.we);
      ee.push_back(t + lat - 1);
      ep.push_back(int'(win));
      if (r.we) begin
        mm[r.addr[7:0]] = r.wdata;
        er.push_back(17'h0);
      end else begin
        er.push_back({1'b1, mm[r.addr[7:0]]});
      end
      t = t + lat + 1;
    end

    pulse_reset();
    e = 0; got = 0;
    present(e, d);
    while (got < ee.size() && e < 400) begin
      tick();
      e++;
      if (p0_ack || p1_ack) begin
        check($sformatf("%s port#%0d", tag, got), 32'(p1_ack), 32'(ep[got]));
        check($sformatf("%s ack_cycle#%0d", tag, got), 32'(e), 32'(ee[got]));
        if (er[got][16]) check($sformatf("%s rdata#%0d", tag, got), 32'(rdata), 32'(er[got][15:0]));
        if (p1_ack) begin if (q1.size() != 0) r = q1.pop_front(); end
        else if (q0.size() != 0) r = q0.pop_front();
        got++;
      end
      present(e, d);
    end
    if (got < ee.size()) check({tag, " ack timeout"}, 32'(got), 32'(ee.size()));
    ref_mem = mm;
    q0.delete();
    q1.delete();
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic gp;
    int lat, acks0, wes0;
    logic [DW-1:0] grd;
    req_t r;

    reset = 1'b1; preload = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    w_req = 0; w_addr = '0; w_zero = '0; w_zbit = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    repeat (3) tick();
    preload = 1'b0;
    check_zero("reset");
    check("reset wait-dut", 32'({w_busy, w_p0_ack, w_p1_ack, w_bus_en, w_ld_mar, w_ld_mdr,
                                 w_sel_mdr, w_mem_we, w_grant_id}), 0);
    reset = 1'b0;
    tick();

    // Port 0 read of 0x0010, strobe by strobe.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    tick();
    check("rd ld_mar strobes", 32'({ld_mar, ld_mdr, sel_mdr, bus_en, mem_we}), 32'b10010);
    check("rd ld_mar bus", 32'(mem_bus), 32'h0010);
    check("rd busy/grant", 32'({busy, grant_id}), 32'b10);
    tick();
    check("rd ld_mdr strobes", 32'({ld_mar, ld_mdr, sel_mdr, bus_en, mem_we}), 32'b01100);
    tick();
    check("rd ack", 32'({p0_ack, p1_ack}), 32'b10);
    check("rd rdata", 32'(rdata), 32'h1234);
    p0_req = 1'b0;
    tick();
    check("rd back idle", 32'({busy, p0_ack, p1_ack}), 0);

    // Port 1 write of 0xBEEF to 0x0020.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0020; p1_wdata = 16'hBEEF;
    tick();
    check("wr ld_mar strobes", 32'({ld_mar, ld_mdr, sel_mdr, bus_en, mem_we}), 32'b10010);
    check("wr ld_mar bus", 32'(mem_bus), 32'h0020);
    check("wr busy/grant", 32'({busy, grant_id}), 32'b11);
    tick();
    check("wr ld_mdr strobes", 32'({ld_mar, ld_mdr, sel_mdr, bus_en, mem_we}), 32'b01010);
    check("wr ld_mdr bus", 32'(mem_bus), 32'hBEEF);
    tick();
    check("wr mem_we strobes", 32'({ld_mar, ld_mdr, sel_mdr, bus_en, mem_we, p0_ack, p1_ack}), 32'b0000100);
    tick();
    check("wr ack", 32'({p0_ack, p1_ack, mem_we}), 32'b010);
    p1_req = 1'b0;
    ref_mem[8'h20] = 16'hBEEF;
    tick();

    // Single-transaction table: read-back, writes, address wrap, latency per operation.
    vt[0] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 4'd3};
    vt[1] = '{1'b1, 1'b1, 16'h0040, 16'h1111, 16'h0000, 4'd4};
    vt[2] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1111, 4'd3};
    vt[3] = '{1'b0, 1'b1, 16'hFFFF, 16'hABCD, 16'h0000, 4'd4};
    vt[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hABCD, 4'd3};
    vt[5] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'h5555, 4'd3};
    vt[6] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h11EE, 4'd3};
    for (int i = 0; i < 7; i++) begin
      do_single(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, gp, lat, grd);
      check($sformatf("vec%0d port", i), 32'(gp), 32'(vt[i].port));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
      if (!vt[i].we) check($sformatf("vec%0d rdata", i), 32'(grd), 32'(vt[i].exp_rdata));
      else ref_mem[vt[i].addr[7:0]] = vt[i].wdata;
    end

    // MEM_WAIT=3 instance: three strobe-free cycles, ack six cycles after sampling.
    w_req = 1'b1; w_addr = 16'h0010;
    tick();
    check("wait ld_mar", 32'({w_ld_mar, w_bus_en, w_mem_bus}), 32'({2'b11, 16'h0010}));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("wait gap%0d", i), 32'({w_busy, w_ld_mar, w_ld_mdr, w_sel_mdr, w_bus_en, w_mem_we, w_p0_ack}),
            32'b1000000);
    end
    tick();
    check("wait ld_mdr", 32'({w_ld_mdr, w_sel_mdr, w_p0_ack}), 32'b110);
    tick();
    check("wait ack", 32'({w_p0_ack, w_p1_ack}), 32'b10);
    check("wait rdata", 32'(w_rdata), 32'h1234);
    w_req = 1'b0;
    tick();

    // Reset during LD_MDR of a port 1 write: abandoned, no write, no ack.
    acks0 = ack_cnt; wes0 = we_cnt;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0030; p1_wdata = 16'hAAAA;
    tick();
    tick();
    check("abort in ld_mdr", 32'({ld_mdr, bus_en, mem_bus}), 32'({2'b11, 16'hAAAA}));
    #2 reset = 1'b1;
    #1;
    check_zero("abort");
    p1_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("abort no mem_we", 32'(we_cnt - wes0), 0);
    check("abort no ack", 32'(ack_cnt - acks0), 0);
    do_single(1'b0, 1'b0, 16'h0030, 16'h0000, gp, lat, grd);
    check("abort old value", 32'(grd), 32'h5555);

    // Simultaneous reads from reset.
    r = '{1'b0, 16'h0010, 16'h0}; q0.push_back(r);
    r = '{1'b0, 16'h0030, 16'h0}; q1.push_back(r);
    run_stream("contend", 0);

    // Port 1 streams loads of 0x0001/0x0002 while port 0 also requests.
    for (int i = 0; i < 4; i++) begin
      r = '{1'b0, 16'(1 + (i % 2)), 16'h0};
      q1.push_back(r);
    end
    r = '{1'b0, 16'h0010, 16'h0}; q0.push_back(r);
    r = '{1'b0, 16'h0011, 16'h0}; q0.push_back(r);
    run_stream("b2b", 1);

    // Randomized mixed streams on a small address set to provoke read/write hazards.
    for (int k = 0; k < 6; k++) begin
      int n0, n1;
      n0 = $urandom_range(0, 6);
      n1 = $urandom_range(1, 6);
      for (int i = 0; i < n0 + n1; i++) begin
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = 16'h0010 + 16'($urandom_range(0, 3));
        r.wdata = 16'($urandom);
        if (i < n0) q0.push_back(r);
        else        q1.push_back(r);
      end
      run_stream($sformatf("rnd%0d", k), int'($urandom_range(0, 6)));
    end

    check("acks never overlap", 32'(overlap_cnt), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
